// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one outstanding access, aligns and masks stores, extends loads,
// and reports misalignment, bad size codes and memory timeouts as errors.
module ysyx_23060332_lsu #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_wdone
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wen_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_n;
  logic          err_q, err_n;
  logic          req_bad;
  logic [31:0]   rsh, load_data;
  logic [3:0]    wmask4;
  logic          accept;

  assign accept = (st == IDLE) && req_valid;

  // Size/alignment legality of the incoming request.
  always_comb begin
    case (req_funct3)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = req_addr[0];
      3'b010:         req_bad = |req_addr[1:0];
      3'b100:         req_bad = req_wen;
      3'b101:         req_bad = req_wen | req_addr[0];
      default:        req_bad = 1'b1;
    endcase
  end

  assign rsh = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  load_data = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  load_data = {24'b0, rsh[7:0]};
      3'b101:  load_data = {16'b0, rsh[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   wmask4 = 4'b0001 << addr_q[1:0];
      2'b01:   wmask4 = 4'b0011 << addr_q[1:0];
      default: wmask4 = 4'b1111;
    endcase
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (st)
      IDLE: begin
        if (req_valid) begin
          cnt_n   = '0;
          rdata_n = '0;
          err_n   = req_bad;
          if (req_bad)      st_n = RESP;
          else if (req_wen) st_n = WR;
          else              st_n = RD;
        end
      end
      RD: begin
        // Data wins over timeout when both land in the same cycle.
        if (mem_rvalid) begin
          rdata_n = load_data;
          st_n    = RESP;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          rdata_n = '0;
          st_n    = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WR: begin
        if (mem_wdone) begin
          st_n = RESP;
        end else if (cnt == CNT_LAST) begin
          err_n = 1'b1;
          st_n  = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
      if (accept) begin
        wen_q   <= req_wen;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Outputs are gated by rst so they drop in the very cycle reset is seen.
  assign req_ready  = !rst && (st == IDLE);
  assign resp_valid = !rst && (st == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;
  assign mem_ren    = !rst && (st == RD) && !wen_q;
  assign mem_wen    = !rst && (st == WR) && wen_q;
  assign mem_raddr  = mem_ren ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_waddr  = mem_wen ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wdata  = mem_wen ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'b0;
  assign mem_wmask  = mem_wen ? {4'b0000, wmask4} : 8'b0;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for the LSU: vector table of single accesses plus reset,
// timeout, data-vs-timeout priority and back-to-back latency sequences.
module tb_ysyx_23060332_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ren, mem_rvalid, mem_wen, mem_wdone;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  ysyx_23060332_lsu #(.TIMEOUT(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wdone(mem_wdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [7:0]  wmask;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string n, logic w, logic [2:0] f, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] mr, logic e, logic [31:0] rd,
                              logic [31:0] ma, logic [31:0] mw, logic [7:0] wm);
    vec_t v;
    v.name = n; v.wen = w; v.f3 = f; v.addr = a; v.wdata = wd; v.mrdata = mr;
    v.err = e; v.rdata = rd; v.maddr = ma; v.mwdata = mw; v.wmask = wm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd);
    req_valid = 1'b1; req_wen = w; req_funct3 = f; req_addr = a; req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
    drive_req(v.wen, v.f3, v.addr, v.wdata);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!v.err) begin
      if (v.wen) begin
        chk({v.name, " wen"}, {31'b0, mem_wen}, 32'd1);
        chk({v.name, " ren"}, {31'b0, mem_ren}, 32'd0);
        chk({v.name, " waddr"}, mem_waddr, v.maddr);
        chk({v.name, " wdata"}, mem_wdata, v.mwdata);
        chk({v.name, " wmask"}, {24'b0, mem_wmask}, {24'b0, v.wmask});
        mem_wdone = 1'b1;
      end else begin
        chk({v.name, " ren"}, {31'b0, mem_ren}, 32'd1);
        chk({v.name, " wen"}, {31'b0, mem_wen}, 32'd0);
        chk({v.name, " raddr"}, mem_raddr, v.maddr);
        mem_rdata = v.mrdata; mem_rvalid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_wdone = 1'b0;
    end else begin
      chk({v.name, " ren"}, {31'b0, mem_ren}, 32'd0);
      chk({v.name, " wen"}, {31'b0, mem_wen}, 32'd0);
    end
    chk({v.name, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({v.name, " resp_err"}, {31'b0, resp_err}, {31'b0, v.err});
    chk({v.name, " resp_rdata"}, resp_rdata, v.rdata);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, " resp drop"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int c0;
    bit seen;
    vecs[0]  = mk("lb",     0, 3'b000, 32'h80000003, 0, 32'h80FF1234, 0, 32'hFFFFFF80, 32'h80000000, 0, 0);
    vecs[1]  = mk("lbu",    0, 3'b100, 32'h80000003, 0, 32'h80FF1234, 0, 32'h00000080, 32'h80000000, 0, 0);
    vecs[2]  = mk("lh2",    0, 3'b001, 32'h80000002, 0, 32'h80FF1234, 0, 32'hFFFF80FF, 32'h80000000, 0, 0);
    vecs[3]  = mk("lhu0",   0, 3'b101, 32'h80000000, 0, 32'h80FF1234, 0, 32'h00001234, 32'h80000000, 0, 0);
    vecs[4]  = mk("lw",     0, 3'b010, 32'h80000004, 0, 32'h12345678, 0, 32'h12345678, 32'h80000004, 0, 0);
    vecs[5]  = mk("lb1",    0, 3'b000, 32'h80000001, 0, 32'h80FF1234, 0, 32'h00000012, 32'h80000000, 0, 0);
    vecs[6]  = mk("sh",     1, 3'b001, 32'h80000002, 32'h0000ABCD, 0, 0, 0, 32'h80000000, 32'hABCD0000, 8'h0C);
    vecs[7]  = mk("sb",     1, 3'b000, 32'h80000001, 32'h123456EE, 0, 0, 0, 32'h80000000, 32'h3456EE00, 8'h02);
    vecs[8]  = mk("sw",     1, 3'b010, 32'h80000004, 32'h12345678, 0, 0, 0, 32'h80000004, 32'h12345678, 8'h0F);
    vecs[9]  = mk("lw_mis", 0, 3'b010, 32'h80000001, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk("lh_mis", 0, 3'b001, 32'h80000003, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk("f3_011", 0, 3'b011, 32'h80000000, 0, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk("sbu",    1, 3'b100, 32'h80000000, 32'h55, 0, 1, 0, 0, 0, 0);
    vecs[13] = mk("sh_mis", 1, 3'b001, 32'h80000001, 32'h55, 0, 1, 0, 0, 0, 0);

    rst = 1'b1; req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_rdata = 0; mem_rvalid = 0; mem_wdone = 0;

    // Reset state and first cycle after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst mem_ren", {31'b0, mem_ren}, 32'd0);
    chk("rst mem_wen", {31'b0, mem_wen}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-rst ready", {31'b0, req_ready}, 32'd1);

    // Stray handshakes while idle must be ignored.
    mem_rvalid = 1'b1; mem_wdone = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle stray resp", {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b0; mem_wdone = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: load with no response lasts exactly TIMEOUT cycles in RD.
    @(negedge clk);
    drive_req(0, 3'b010, 32'h80000000, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (mem_ren && n < 1000) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("timeout cycles", n, 256);
    chk("timeout resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("timeout resp_err", {31'b0, resp_err}, 32'd1);
    chk("timeout resp_rdata", resp_rdata, 32'd0);

    // Data arriving on the final timeout cycle wins.
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 3'b010, 32'h80000008, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (255) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("prio still RD", {31'b0, mem_ren}, 32'd1);
    mem_rdata = 32'hCAFEF00D; mem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("prio resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("prio resp_err", {31'b0, resp_err}, 32'd0);
    chk("prio resp_rdata", resp_rdata, 32'hCAFEF00D);

    // Reset pulsed during WR abandons the store.
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 3'b010, 32'h80000010, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr-rst wen before", {31'b0, mem_wen}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("wr-rst wen after", {31'b0, mem_wen}, 32'd0);
    chk("wr-rst resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("wr-rst ready", {31'b0, req_ready}, 32'd1);
    repeat (3) begin
      seen = seen | resp_valid | mem_wen;
      @(posedge clk);
      @(negedge clk);
    end
    chk("wr-rst no activity", {31'b0, seen}, 32'd0);

    // Back-to-back sw then lw: responses at N+2 and N+5.
    c0 = 0;
    drive_req(1, 3'b010, 32'h80000004, 32'h12345678);
    @(posedge clk); c0++;
    @(negedge clk);
    drive_req(0, 3'b010, 32'h80000004, 0);
    mem_wdone = 1'b1;
    @(posedge clk); c0++;
    @(negedge clk);
    mem_wdone = 1'b0;
    chk("b2b sw resp N+2", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); c0++;
    @(negedge clk);
    chk("b2b ready N+3", {31'b0, req_ready}, 32'd1);
    @(posedge clk); c0++;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b lw raddr", mem_raddr, 32'h80000004);
    mem_rdata = 32'h12345678; mem_rvalid = 1'b1;
    @(posedge clk); c0++;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("b2b lw resp N+5", {31'b0, resp_valid}, 32'd1);
    chk("b2b cycle", c0, 5);
    chk("b2b lw rdata", resp_rdata, 32'h12345678);
    chk("b2b lw err", {31'b0, resp_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_lsu.md
YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256: maximum cycles spent in RD/WR waiting for memory before an error response.
REQ-002 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  core request valid.
REQ-005 SHALL have port req_ready  out  1  LSU can accept a request.
REQ-006 SHALL have port req_wen  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  32  extended load data.
REQ-012 SHALL have port resp_err  out  1  misaligned access, illegal size code or timeout.
REQ-013 SHALL have ports mem_ren out 1, mem_raddr out 32, mem_rdata in 32, mem_rvalid in 1: memory read channel.
REQ-014 SHALL have ports mem_wen out 1, mem_waddr out 32, mem_wdata out 32, mem_wmask out 8, mem_wdone in 1: memory write channel.

Function
REQ-015 SHALL implement a state machine with states IDLE, RD, WR and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and wen, funct3, addr and wdata are latched at acceptance.
REQ-017 SHALL treat these as errors: h/hu with addr[0]=1; w with addr[1:0]!=0; funct3 011, 110 or 111; a store with 100 or 101.
REQ-018 SHALL, on an error request, go directly to RESP with resp_err=1 and never assert mem_ren or mem_wen.
REQ-019 SHALL, in RD, hold mem_ren=1 and mem_raddr={addr[31:2],2'b00} until mem_rvalid=1.
REQ-020 SHALL, on mem_rvalid, select the byte or halfword lane from addr[1:0], sign-extend (b, h) or zero-extend (bu, hu, w), register the result into resp_rdata, and go to RESP.
REQ-021 SHALL, in WR, hold mem_wen=1, mem_waddr={addr[31:2],2'b00}, mem_wdata=wdata shifted left by 8*addr[1:0], and mem_wmask[3:0] as sb 0001<<addr[1:0], sh 0011<<addr[1:0], sw 1111, with mem_wmask[7:4]=0, until mem_wdone=1; then go to RESP.
REQ-022 SHALL count cycles spent in RD/WR; on reaching TIMEOUT without mem_rvalid/mem_wdone, go to RESP with resp_err=1 and resp_rdata=0.
REQ-023 SHALL give data priority over timeout when mem_rvalid/mem_wdone coincides with the timeout cycle (no error).
REQ-024 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-025 SHALL drive resp_rdata=0 for stores and for errors; resp_err=0 whenever resp_valid=0.
REQ-026 SHALL give latency as: accept in cycle N, RD/WR in N+1, and with a same-cycle mem_rvalid/mem_wdone, resp_valid in N+2 and next accept in N+3.
REQ-027 SHALL ignore mem_rvalid and mem_wdone outside RD/WR; mem_ren and mem_wen SHALL never both be 1.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, counter 0, and all outputs 0, including req_ready.
REQ-029 SHALL make req_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL, on rst mid-transaction, abandon it: no resp_valid, and mem_ren/mem_wen are 0 from the next cycle.

Verification
REQ-031 SHALL pass: lb at 0x80000003, mem_rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80; lbu -> 0x00000080; resp_err=0.
REQ-032 SHALL pass: sh at 0x80000002, wdata=0x0000ABCD -> mem_waddr=0x80000000, mem_wdata=0xABCD0000, mem_wmask=8'h0C.
REQ-033 SHALL pass: lw at 0x80000001 -> resp_valid with resp_err=1 one cycle after acceptance; mem_ren never 1.
REQ-034 SHALL pass: load with mem_rvalid held 0 -> resp_err=1, resp_rdata=0 after TIMEOUT cycles in RD.
REQ-035 SHALL pass: rst pulsed during WR -> mem_wen=0 next cycle, no resp_valid, req_ready=1 after release.
REQ-036 SHALL pass: sw 0x12345678 at 0x80000004 then lw same address with immediate mem_rvalid=0x12345678 -> resp_valid at N+2 and N+5, resp_rdata=0x12345678.
